// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared ROM-side constants, fetch FSM state encodings and small helpers
// for the instruction fetch controller and its prefetch FIFO.
package inst_fetch_ctrl_pkg;

    // ROM interface widths and constant values
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic [31:0] PcStep      = 32'h0000_0004;
    localparam logic [31:0] CntMax      = 32'hFFFF_FFFF;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // One prefetch FIFO entry: fetch address plus returned instruction word
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Saturating 32-bit increment used by the event counters
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == CntMax) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_prefetch_fifo.sv
// Prefetch FIFO (module if_prefetch_fifo): DEPTH entries of {pc, inst}.
// Flush has priority over push/pop. Push while full is accepted only when
// the head is popped in the same cycle. An empty FIFO presents all-zero
// head data.
module if_prefetch_fifo
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output fetch_entry_t               head_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t      mem_r [DEPTH];
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic              pop_ok_s;
    logic              push_ok_s;
    logic              full_s;
    logic              empty_s;

    // Qualify push/pop against occupancy so the pointers can never corrupt
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        full_s    = (count_r == CW'(DEPTH));
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (!empty_s) begin
            pop_ok_s = pop;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (!full_s || pop_ok_s) begin
            push_ok_s = push;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy; flush discards every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry toward the consumer, zero when nothing is queued
    always_comb begin
        head_data = '0;
        if (!empty_s) begin
            head_data = mem_r[rd_ptr_r];
        end else begin
            head_data = '0;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the combinational instruction ROM
// port, sequences fetch addresses, buffers returned words in a prefetch
// FIFO and hands {pc, inst} to IF/ID over valid/ready. Handles stalls,
// redirects (flush + new PC) and fetch halt.
// Optional build macro IFETCH_PERF_CNT_EN adds saturating event counters
// perf_issue_cnt, perf_flush_cnt and perf_full_cnt.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redirect_valid,
    input  logic [InstAddrBus-1:0] redirect_pc,
    output logic                   rom_ce,
    output logic [InstAddrBus-1:0] rom_addr,
    input  logic [InstBus-1:0]     rom_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [InstAddrBus-1:0] out_pc,
    output logic [InstBus-1:0]     out_inst
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_issue_cnt,
    output logic [31:0]            perf_flush_cnt,
    output logic [31:0]            perf_full_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e           state_r;
    logic [InstAddrBus-1:0] fetch_pc_r;
    logic [CW-1:0]          count_s;
    fetch_entry_t           head_s;
    fetch_entry_t           push_data_s;
    logic                   fifo_full_s;
    logic                   out_valid_s;
    logic                   pop_s;
    logic                   issue_s;
    logic                   run_s;

    // Issue / pop decisions from registered state; redirect masks both
    always_comb begin
        run_s       = (state_r == ST_RUN);
        fifo_full_s = (count_s == CW'(DEPTH));
        out_valid_s = (count_s != {CW{1'b0}}) & ~redirect_valid;
        pop_s       = out_valid_s & out_ready;
        issue_s     = run_s & ~redirect_valid & (~fifo_full_s | pop_s);
        push_data_s = '{pc: fetch_pc_r, inst: rom_inst};
    end

    // ROM port and consumer-facing outputs
    always_comb begin
        rom_ce   = ChipDisable;
        rom_addr = ZeroWord;
        if (issue_s) begin
            rom_ce   = ChipEnable;
            rom_addr = fetch_pc_r;
        end else begin
            rom_ce   = ChipDisable;
            rom_addr = ZeroWord;
        end
        out_valid = out_valid_s;
        out_pc    = head_s.pc;
        out_inst  = head_s.inst;
    end

    // Fetch FSM and PC register; redirect reloads the PC in any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= fetch_en ? ST_RUN  : ST_IDLE;
                ST_RUN:  state_r <= fetch_en ? ST_RUN  : ST_HALT;
                ST_HALT: state_r <= fetch_en ? ST_RUN  : ST_HALT;
                default: state_r <= ST_IDLE;
            endcase
            if (redirect_valid) begin
                fetch_pc_r <= align_word(redirect_pc);
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + PcStep;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

    if_prefetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (count_s),
        .head_data (head_s)
    );

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] issue_cnt_r;
    logic [31:0] flush_cnt_r;
    logic [31:0] full_cnt_r;
    logic        full_block_s;

    // A run-state cycle counts as blocked-full when only occupancy stops issue
    always_comb begin
        full_block_s = run_s & ~redirect_valid & fifo_full_s & ~pop_s;
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
            full_cnt_r  <= 32'h0000_0000;
        end else begin
            if (issue_s) begin
                issue_cnt_r <= sat_inc32(issue_cnt_r);
            end
            if (redirect_valid) begin
                flush_cnt_r <= sat_inc32(flush_cnt_r);
            end
            if (full_block_s) begin
                full_cnt_r <= sat_inc32(full_cnt_r);
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_r;
    assign perf_flush_cnt = flush_cnt_r;
    assign perf_full_cnt  = full_cnt_r;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a queue-based reference model
// checked every cycle, directed scenarios with hand-computed values, and
// a randomized phase with occasional asynchronous reset pulses.
module tb_inst_fetch_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_ready = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_full_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_pc;
    bit          m_run;
    bit          e_valid;
    bit          e_pop;
    bit          e_ce;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign rom_inst = rom_fn(rom_addr);

    inst_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0000_0000;
        m_run = 1'b0;
    endtask

    // Compare DUT outputs against the model mid-cycle (falling edge)
    task automatic cmp_cycle();
        @(negedge clk);
        e_valid = (mq.size() != 0) && !redirect_valid;
        e_pop   = e_valid && out_ready;
        e_ce    = m_run && !redirect_valid && ((mq.size() < DEPTH) || e_pop);
        chk("rom_ce", 32'(rom_ce), 32'(e_ce));
        chk("rom_addr", rom_addr, e_ce ? m_pc : 32'h0);
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        if (e_valid) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_inst", out_inst, rom_fn(mq[0]));
        end else if (mq.size() == 0) begin
            chk("empty_pc", out_pc, 32'h0);
            chk("empty_inst", out_inst, 32'h0);
        end
    endtask

    // Advance the model across the rising edge
    task automatic adv();
        @(posedge clk);
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_ce) begin
                mq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        m_run = fetch_en;
        #1;
    endtask

    task automatic step();
        cmp_cycle();
        adv();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_rom_ce", 32'(rom_ce), 32'h0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_perf_issue", perf_issue_cnt, 32'h0);
        chk("rst_perf_flush", perf_flush_cnt, 32'h0);
        chk("rst_perf_full", perf_full_cnt, 32'h0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n_ce;
        model_reset();

        // Sequential streaming from reset
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        do_reset();
        step();
        cmp_cycle();
        chk("c1_ce", 32'(rom_ce), 32'h1);
        chk("c1_addr", rom_addr, 32'h0);
        adv();
        cmp_cycle();
        chk("c2_valid", 32'(out_valid), 32'h1);
        chk("c2_pc", out_pc, 32'h0);
        adv();
        for (int i = 0; i < 10; i++) begin
            cmp_cycle();
            chk("stream_pc", out_pc, 32'(4 * (i + 1)));
            adv();
        end

        // Back-pressure: exactly DEPTH issues then drain in order
        out_ready = 1'b0;
        cmp_cycle();
        do_reset();
        n_ce = 0;
        for (int i = 0; i < 10; i++) begin
            cmp_cycle();
            if (rom_ce) n_ce++;
            if (i >= 2) chk("stall_pc", out_pc, 32'h0);
            adv();
        end
        chk("stall_issues", 32'(n_ce), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmp_cycle();
            chk("drain_valid", 32'(out_valid), 32'h1);
            chk("drain_pc", out_pc, 32'(4 * i));
            adv();
        end

        // Redirect with three entries queued
        out_ready = 1'b0;
        cmp_cycle();
        do_reset();
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cmp_cycle();
        chk("redir_valid_mask", 32'(out_valid), 32'h0);
        chk("redir_ce_mask", 32'(rom_ce), 32'h0);
        adv();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        cmp_cycle();
        chk("redir_issue_ce", 32'(rom_ce), 32'h1);
        chk("redir_issue_addr", rom_addr, 32'h0000_0100);
        adv();
        cmp_cycle();
        chk("redir_out_valid", 32'(out_valid), 32'h1);
        chk("redir_out_pc", out_pc, 32'h0000_0100);
        adv();

        // Back-to-back redirects: the second target wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_pc    = 32'h0000_0080;
        cmp_cycle();
        chk("b2b_ce", 32'(rom_ce), 32'h0);
        adv();
        redirect_valid = 1'b0;
        cmp_cycle();
        chk("b2b_addr", rom_addr, 32'h0000_0080);
        chk("b2b_empty", 32'(out_valid), 32'h0);
        adv();
        cmp_cycle();
        chk("b2b_out_pc", out_pc, 32'h0000_0080);
        adv();

        // Fetch address wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFA;
        step();
        redirect_valid = 1'b0;
        cmp_cycle();
        chk("wrap_a0", rom_addr, 32'hFFFF_FFF8);
        adv();
        cmp_cycle();
        chk("wrap_a1", rom_addr, 32'hFFFF_FFFC);
        adv();
        cmp_cycle();
        chk("wrap_a2", rom_addr, 32'h0000_0000);
        adv();
        repeat (3) step();

        // Halt with entries queued: drain, then resume sequentially
        out_ready = 1'b0;
        cmp_cycle();
        do_reset();
        repeat (3) step();
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        fetch_en = 1'b1;
        cmp_cycle();
        chk("halt_valid", 32'(out_valid), 32'h0);
        chk("halt_ce", 32'(rom_ce), 32'h0);
        adv();
        cmp_cycle();
        chk("resume_ce", 32'(rom_ce), 32'h1);
        chk("resume_addr", rom_addr, 32'h0000_000C);
        adv();
        repeat (3) step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            fetch_en       = ($urandom_range(0, 99) < 85);
            out_ready      = ($urandom_range(0, 99) < 65);
            redirect_valid = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) begin
                redirect_pc = 32'hFFFF_FFE0 | ($urandom() & 32'h0000_001F);
            end else begin
                redirect_pc = $urandom();
            end
            cmp_cycle();
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                adv();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
